// File: rtl/main_memory_pkg.sv
// Shared widths and FSM state type for the main_memory block.
package main_memory_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } mem_state_t;

endpackage

// File: rtl/main_memory_array.sv
// Single-port word storage: synchronous write, combinational read on the same address.
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Storage is deliberately left out of reset so committed writes survive it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/main_memory.sv
// Fixed-latency memory: single-word writes, critical-word-first wrapping line reads.
// Optional MAIN_MEMORY_STATS_EN adds saturating rd_count/wr_count outputs.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              wr_done
`ifdef MAIN_MEMORY_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = IDX_W - OFF_W;

    mem_state_t          r_state;
    mem_state_t          w_next;
    logic [3:0]          r_lat;
    logic                r_is_write;
    logic [LINE_W-1:0]   r_line;
    logic [OFF_W-1:0]    r_off;
    logic [OFF_W-1:0]    r_beat;

    logic [IDX_W-1:0]    w_req_idx;
    logic [IDX_W-1:0]    w_mem_addr;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_accept;
    logic                w_unused;

    // Word index wraps modulo the storage depth; byte-lane bits are dropped.
    assign w_req_idx = IDX_W'(req_addr[ADDR_W-1:2]);
    assign w_unused  = &{1'b0, req_addr};
    assign w_accept  = req_valid && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        wr_done    = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = w_req_idx;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next   = WAIT;
                    w_mem_we = req_write;
                end
            end
            WAIT: begin
                if (r_lat == 4'd0) begin
                    w_next = r_is_write ? WACK : BURST;
                end
            end
            BURST: begin
                rsp_valid  = 1'b1;
                w_mem_addr = {r_line, r_off};
                rsp_last   = (r_beat == '1);
                if (rsp_ready && rsp_last) begin
                    w_next = IDLE;
                end
            end
            WACK: begin
                wr_done = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign rsp_data = rsp_valid ? w_mem_rdata : '0;

    // Accept edge loads LATENCY-1 so the response state is entered LATENCY edges later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat      <= '0;
            r_is_write <= 1'b0;
            r_line     <= '0;
            r_off      <= '0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_lat      <= 4'(LATENCY - 1);
                        r_is_write <= req_write;
                        r_line     <= w_req_idx[IDX_W-1:OFF_W];
                        r_off      <= w_req_idx[OFF_W-1:0];
                        r_beat     <= '0;
                    end
                end
                WAIT: begin
                    if (r_lat != 4'd0) begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                BURST: begin
                    if (rsp_ready) begin
                        r_off  <= r_off + OFF_W'(1);
                        r_beat <= r_beat + OFF_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    main_memory_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (req_wdata),
        .o_rdata (w_mem_rdata)
    );

`ifdef MAIN_MEMORY_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_accept) begin
            if (!req_write && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (req_write && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule
